// File: rtl/roulette_ring.sv
// roulette_ring: one-hot spinning ring with a prescaled step clock and a decelerating stop
// Ports: clk          rising-edge clock
//        rst          synchronous active-high reset
//        start        level, begins spinning from IDLE (speed latched here)
//        stop         level, begins deceleration from SPIN
//        speed[1:0]   base step period select, B = 2^(DIV_W-3+speed)
//        dir          rotation direction (0 toward MSB, 1 toward LSB), used with ROULETTE_DIR_EN
//        ring         one-hot position
//        seg_n        active-low display drive, ~{1'b0, ring}
//        pos          binary index of the set ring bit
//        busy         high while spinning or decelerating
//        done         one-cycle pulse on the final decelerating step
// Macro: ROULETTE_DIR_EN enables the dir input; otherwise rotation is always toward MSB.
module roulette_ring #(
    parameter int RING_W     = 6,
    parameter int DIV_W      = 22,
    parameter int SLOW_STEPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                speed,
    input  logic                      dir,
    output logic [RING_W-1:0]         ring,
    output logic [RING_W:0]           seg_n,
    output logic [$clog2(RING_W)-1:0] pos,
    output logic                      busy,
    output logic                      done
);
    localparam int PW = DIV_W + SLOW_STEPS;
    localparam int KW = $clog2(SLOW_STEPS + 1);
    localparam int AW = $clog2(RING_W);

    typedef enum logic [1:0] {IDLE, SPIN, SLOW} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [1:0]        spd_q, spd_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic              done_q, done_d;
    logic [PW-1:0]     lim;
    logic              tick, step, down;
    int                sh;

`ifdef ROULETTE_DIR_EN
    assign down = dir;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign down = 1'b0;
`endif

    // k is zero in SPIN, so one shift covers both B and B<<k; a shift of PW yields all ones
    assign sh   = DIV_W - 3 + int'(spd_q) + int'(k_q);
    assign lim  = ~({PW{1'b1}} << sh);
    assign tick = cnt_q == lim;

    assign ring  = ring_q;
    assign seg_n = ~{1'b0, ring_q};
    assign pos   = pos_q;
    assign busy  = state_q != IDLE;
    assign done  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            spd_q   <= '0;
            ring_q  <= RING_W'(1);
            pos_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            spd_q   <= spd_d;
            ring_q  <= ring_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        k_d     = k_q;
        done_d  = 1'b0;
        step    = (state_q != IDLE) && tick;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + PW'(1);
        ring_d  = !step ? ring_q :
                  down  ? {ring_q[0], ring_q[RING_W-1:1]} : {ring_q[RING_W-2:0], ring_q[RING_W-1]};
        pos_d   = !step ? pos_q :
                  down  ? ((pos_q == '0) ? AW'(RING_W - 1) : pos_q - AW'(1)) :
                          ((pos_q == AW'(RING_W - 1)) ? '0 : pos_q + AW'(1));
        case (state_q)
            IDLE: if (start) begin
                state_d = SPIN;
                spd_d   = speed;
            end
            SPIN: if (stop) begin
                state_d = SLOW;
                cnt_d   = '0;
                k_d     = KW'(1);
            end
            SLOW: if (tick) begin
                state_d = (k_q == KW'(SLOW_STEPS)) ? IDLE : SLOW;
                done_d  = k_q == KW'(SLOW_STEPS);
                k_d     = (k_q == KW'(SLOW_STEPS)) ? '0 : k_q + KW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_roulette_ring.sv
// tb_roulette_ring: directed self-checking bench for roulette_ring (RING_W=6, DIV_W=4, SLOW_STEPS=2)
module tb_roulette_ring;
    logic       clk = 1'b0;
    logic       rst, start, stop, dir;
    logic [1:0] speed;
    logic [5:0] ring;
    logic [6:0] seg_n;
    logic [2:0] pos;
    logic       busy, done;
    int         checks = 0;
    int         failures = 0;
    int         done_seen;

    roulette_ring #(.RING_W(6), .DIV_W(4), .SLOW_STEPS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .speed(speed), .dir(dir),
        .ring(ring), .seg_n(seg_n), .pos(pos), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; speed = 2'd0; dir = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("rst_ring", ring, 6'b000001);
        chk("rst_seg", seg_n, 7'b1111110);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        // spin at speed 0: B = 2
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("spin_busy", busy, 1);
        cyc(1);
        chk("spin_no_early", ring, 6'b000001);
        cyc(1);
        chk("spin_step1", ring, 6'b000010);
        chk("spin_pos1", pos, 1);
        for (int i = 2; i < 6; i++) begin
            cyc(2);
            chk("spin_ring", ring, 32'(1) << i);
            chk("spin_pos", pos, i);
        end
        cyc(2);
        chk("wrap_ring", ring, 6'b000001);
        chk("wrap_pos", pos, 0);
        // decelerate: 4 cycles then 8 cycles
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("slow_busy", busy, 1);
        cyc(3);
        chk("slow_hold1", ring, 6'b000001);
        cyc(1);
        chk("slow_step1", ring, 6'b000010);
        chk("slow_done1", done, 0);
        stop = 1'b1;
        cyc(7);
        stop = 1'b0;
        chk("slow_hold2", ring, 6'b000010);
        chk("slow_nodone", done, 0);
        cyc(1);
        chk("final_ring", ring, 6'b000100);
        chk("final_pos", pos, 2);
        chk("final_done", done, 1);
        chk("final_busy", busy, 0);
        cyc(1);
        chk("done_pulse", done, 0);
        stop = 1'b1;
        cyc(20);
        stop = 1'b0;
        chk("idle_hold", ring, 6'b000100);
        chk("idle_busy", busy, 0);
        // speed 3: B = 16, latched at start, restart attempts ignored
        speed = 2'd3; start = 1'b1;
        cyc(1);
        speed = 2'd0;
        cyc(5);
        start = 1'b0;
        cyc(10);
        chk("slow_spd_hold", ring, 6'b000100);
        cyc(1);
        chk("slow_spd_step", ring, 6'b001000);
        chk("slow_spd_pos", pos, 3);
        cyc(15);
        chk("slow_spd_hold2", ring, 6'b001000);
        cyc(1);
        chk("slow_spd_step2", ring, 6'b010000);
        // reset during SLOW aborts silently
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("abort_busy", busy, 1);
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("abort_ring", ring, 6'b000001);
        chk("abort_pos", pos, 0);
        chk("abort_busy0", busy, 0);
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_ring_hold", ring, 6'b000001);
        // direction
        dir = 1'b1; speed = 2'd0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
`ifdef ROULETTE_DIR_EN
        chk("dir_ring", ring, 6'b100000);
        chk("dir_pos", pos, 5);
`else
        chk("dir_ring", ring, 6'b000010);
        chk("dir_pos", pos, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
